adder_sub_stim_check: RTL and testbench
=======================================

// Module: adder_sub_stim_check
// PURPOSE
// Self-running exhaustive stimulus generator and result checker for the W-bit adder_sub block.
// Drives every {control, carry_in, in1, in2} combination into the DUT and reads back out/carry_out.
// Compares each result against an internal golden model, counts mismatches and latches the first failing vector.
// Sits beside the adder_sub datapath as on-chip BIST; start/busy/done handshake toward the test controller.
// PARAMETERS
// W    4  operand width of the DUT (in1, in2, out)
// LAT  0  DUT result latency in cycles: 0 = combinational, 1..3 = registered stages
// PORTS
// clk        in   1      single clock, rising edge
// rst_n      in   1      asynchronous active-low reset
// start      in   1      pulse/level; sampled only in IDLE or DONE
// dut_out    in   W      DUT sum/difference
// dut_cout   in   1      DUT carry_out
// in1        out  W      operand A to DUT
// in2        out  W      operand B to DUT
// carry_in   out  1      carry input to DUT
// control    out  1      0 = add, 1 = subtract
// busy       out  1      high in RUN and DRAIN
// done       out  1      high in DONE until next start or reset
// pass       out  1      valid while done: 1 iff err_count == 0
// err_count  out  2W+3   mismatch count, saturating at all-ones
// fail_idx   out  2W+2   index of first mismatching vector (valid when err_count != 0)
// fail_out   out  W      dut_out captured at first mismatch
// fail_cout  out  1      dut_cout captured at first mismatch
// BEHAVIOUR
// - Golden model: B = in2 ^ {W{control}}; {cout, out} = in1 + B + carry_in, computed at W+1 bits.
// - Vector index idx[2W+1:0] = {control, carry_in, in1, in2}, stepping 0 .. 2^(2W+2)-1 (1024 for W=4).
// - DUT drive outputs are registered straight from idx.
// - Reset (async, any state): state = IDLE; all outputs = 0; idx = 0; expected-value delay line cleared.
// - FSM:
//   - IDLE:  start -> RUN; idx = 0; err_count, fail_* cleared.
//   - RUN:   each edge checks the vector driven LAT cycles earlier and advances idx.
//            After the edge that drives the last idx, go to DRAIN (LAT > 0) or DONE (LAT = 0).
//   - DRAIN: hold the drive outputs at the last vector; check the LAT outstanding results, then -> DONE.
//   - DONE:  done = 1, pass valid; start -> RUN with a fresh run (same clearing as IDLE).
// - start while busy: ignored.
// - Checking pipeline:
//   - Expected {cout, out} and idx travel through a LAT-deep shift register alongside the DUT.
//   - A compare occurs only when the delay-line valid bit is set, so no compares happen in the first LAT cycles.
// - Mismatch (either dut_out or dut_cout differs):
//   - err_count += 1, saturating.
//   - On the first mismatch only, capture fail_idx/fail_out/fail_cout; later mismatches leave them unchanged.
// - Timing: with LAT=0, done rises exactly 2^(2W+2) cycles after the edge that sampled start; each LAT adds 1 cycle.
// - Reset mid-run: the run is abandoned; the counts are lost, and a new start is required.
// TESTING
// - Correct behavioural adder_sub, LAT=0, W=4:
//   start -> done after 1024 cycles, pass=1, err_count=0.
// - DUT with out[0] stuck-at-0:
//   err_count=512, fail_idx=10'h001, fail_out=4'b0000, fail_cout=0, pass=0.
// - DUT with inverted carry_out:
//   err_count=1024, fail_idx=0, fail_cout=1.
// - Spot-check the drive at idx = {1,1,0111,0011}:
//   golden out=4'b0100, cout=1 (7-3); correct DUT gives no error.
// - LAT=2 with a 2-stage registered DUT:
//   done after 1026 cycles, pass=1; the first compare occurs on the 3rd edge after start.
// - Reset and restart handling:
//   - Deassert rst_n at idx=300 -> all outputs 0 and state IDLE.
//   - A new start then runs all 1024 vectors.
//   - start pulsed mid-run has no effect.
//   - start in DONE restarts with err_count cleared.

Source files
------------

// File: rtl/adder_sub_stim_check.sv
// adder_sub_stim_check
//   On-chip BIST for the W-bit adder_sub datapath. After a start request it
//   walks every {control, carry_in, in1, in2} vector into the DUT. It checks
//   each result against a golden add/subtract model, counts mismatches, and
//   captures the first failing vector.
//
// Parameters
//   W    operand width of the DUT
//   LAT  DUT result latency in cycles (0 = combinational, 1..3 = registered)
//
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   start      in   1       run request, sampled only in IDLE or DONE
//   dut_out    in   W       DUT sum/difference
//   dut_cout   in   1       DUT carry_out
//   in1        out  W       operand A to DUT
//   in2        out  W       operand B to DUT
//   carry_in   out  1       carry input to DUT
//   control    out  1       0 = add, 1 = subtract
//   busy       out  1       run in progress (RUN or DRAIN)
//   done       out  1       run finished, held until next start or reset
//   pass       out  1       done and no mismatches seen
//   err_count  out  2W+3    saturating mismatch count
//   fail_idx   out  2W+2    index of first mismatching vector
//   fail_out   out  W       dut_out captured at first mismatch
//   fail_cout  out  1       dut_cout captured at first mismatch
module adder_sub_stim_check #(
    parameter int W   = 4,
    parameter int LAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     dut_out,
    input  logic             dut_cout,
    output logic [W-1:0]     in1,
    output logic [W-1:0]     in2,
    output logic             carry_in,
    output logic             control,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [2*W+2:0]   err_count,
    output logic [2*W+1:0]   fail_idx,
    output logic [W-1:0]     fail_out,
    output logic             fail_cout
);

    localparam int IW = 2 * W + 2;
    localparam logic [IW-1:0]  IDX_LAST = '1;
    localparam logic [IW:0]    ERR_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   idx;
    logic            drv_valid;
    logic            start_run;

    // Stage 0 of the check pipeline: the vector currently on the drive pins.
    logic [W-1:0]    gold_b;
    logic [W:0]      exp0;

    // Compare point: the entry whose DUT result is present this cycle.
    logic            cmp_valid;
    logic [W:0]      cmp_exp;
    logic [IW-1:0]   cmp_idx;
    logic            cmp_last;
    logic            mismatch;

    // Drive pins come straight from the index register.
    assign control  = idx[IW-1];
    assign carry_in = idx[IW-2];
    assign in1      = idx[2*W-1:W];
    assign in2      = idx[W-1:0];

    always_comb begin
        gold_b = in2 ^ {W{control}};
        exp0   = {1'b0, in1} + {1'b0, gold_b} + {{W{1'b0}}, carry_in};
    end

    generate
        if (LAT == 0) begin : g_comb
            assign cmp_valid = drv_valid;
            assign cmp_exp   = exp0;
            assign cmp_idx   = idx;
        end else begin : g_delay
            logic          dl_valid [LAT];
            logic [W:0]    dl_exp   [LAT];
            logic [IW-1:0] dl_idx   [LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < LAT; i++) begin
                        dl_valid[i] <= 1'b0;
                        dl_exp[i]   <= '0;
                        dl_idx[i]   <= '0;
                    end
                end else begin
                    dl_valid[0] <= drv_valid;
                    dl_exp[0]   <= exp0;
                    dl_idx[0]   <= idx;
                    for (int unsigned i = 1; i < LAT; i++) begin
                        dl_valid[i] <= dl_valid[i-1];
                        dl_exp[i]   <= dl_exp[i-1];
                        dl_idx[i]   <= dl_idx[i-1];
                    end
                end
            end

            assign cmp_valid = dl_valid[LAT-1];
            assign cmp_exp   = dl_exp[LAT-1];
            assign cmp_idx   = dl_idx[LAT-1];
        end
    endgenerate

    assign cmp_last  = cmp_valid && (cmp_idx == IDX_LAST);
    assign mismatch  = cmp_valid && ({dut_cout, dut_out} != cmp_exp);
    assign start_run = start && ((state == IDLE) || (state == DONE));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = RUN;
            // The run ends when the last vector's result has been checked.
            // With LAT = 0 that happens in RUN. Otherwise, DRAIN covers the
            // cycles in which results are still in flight.
            RUN: begin
                if (cmp_last)
                    state_nxt = DONE;
                else if ((LAT > 0) && drv_valid && (idx == IDX_LAST))
                    state_nxt = DRAIN;
            end
            DRAIN: if (cmp_last) state_nxt = DONE;
            DONE:  if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            drv_valid <= 1'b0;
            err_count <= '0;
            fail_idx  <= '0;
            fail_out  <= '0;
            fail_cout <= 1'b0;
        end else if (start_run) begin
            idx       <= '0;
            drv_valid <= 1'b1;
            err_count <= '0;
            fail_idx  <= '0;
            fail_out  <= '0;
            fail_cout <= 1'b0;
        end else begin
            // Once the last vector is issued, idx holds it on the pins.
            if ((state == RUN) && drv_valid) begin
                if (idx != IDX_LAST)
                    idx <= idx + 1'b1;
                else
                    drv_valid <= 1'b0;
            end
            if (mismatch) begin
                if (err_count != ERR_MAX)
                    err_count <= err_count + 1'b1;
                if (err_count == '0) begin
                    fail_idx  <= cmp_idx;
                    fail_out  <= dut_out;
                    fail_cout <= dut_cout;
                end
            end
        end
    end

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);
    assign pass = (state == DONE) && (err_count == '0);

endmodule

// File: tb/tb_adder_sub_stim_check.sv
module tb_adder_sub_stim_check;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // DUT 0: LAT = 0 with a combinational adder_sub model.
    logic        start0 = 1'b0;
    logic [3:0]  in1_0, in2_0, dout0, fout0;
    logic        cin0, ctrl0, dcout0, busy0, done0, pass0, fcout0;
    logic [10:0] err0;
    logic [9:0]  fidx0;
    int          fault0 = 0;

    // DUT 2: LAT = 2 with a two-stage registered adder_sub model.
    logic        start2 = 1'b0;
    logic [3:0]  in1_2, in2_2, dout2, fout2;
    logic        cin2, ctrl2, dcout2, busy2, done2, pass2, fcout2;
    logic [10:0] err2;
    logic [9:0]  fidx2;
    int          fault2 = 0;

    adder_sub_stim_check #(.W(4), .LAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .dut_out(dout0), .dut_cout(dcout0),
        .in1(in1_0), .in2(in2_0), .carry_in(cin0), .control(ctrl0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_idx(fidx0), .fail_out(fout0), .fail_cout(fcout0)
    );

    adder_sub_stim_check #(.W(4), .LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .dut_out(dout2), .dut_cout(dcout2),
        .in1(in1_2), .in2(in2_2), .carry_in(cin2), .control(ctrl2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .fail_idx(fidx2), .fail_out(fout2), .fail_cout(fcout2)
    );

    // Fault modes: 0 = correct, 1 = out[0] stuck at 0, 2 = carry_out inverted.
    function automatic logic [4:0] addsub(input logic [3:0] a, input logic [3:0] b,
                                          input logic ci, input logic ctl, input int f);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b ^ {4{ctl}}} + {4'b0, ci};
        if (f == 1) s[0] = 1'b0;
        if (f == 2) s[4] = ~s[4];
        return s;
    endfunction

    always_comb {dcout0, dout0} = addsub(in1_0, in2_0, cin0, ctrl0, fault0);

    logic [4:0] st1, st2;
    always @(posedge clk) begin
        st1 <= addsub(in1_2, in2_2, cin2, ctrl2, fault2);
        st2 <= st1;
    end
    assign {dcout2, dout2} = st2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard: one expected end-of-run record per run that should finish.
    typedef struct {
        logic [10:0] err;
        logic [9:0]  fidx;
        logic [3:0]  fout;
        logic        fcout;
        logic        pass;
        int unsigned cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q2[$];

    logic done0_q = 1'b0;
    logic done2_q = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (done0 && !done0_q) begin
            if (q0.size() == 0) begin
                chk("dut0_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                chk("dut0_done_cycle", cyc, e.cyc);
                chk("dut0_err_count", {21'd0, err0}, {21'd0, e.err});
                chk("dut0_pass", {31'd0, pass0}, {31'd0, e.pass});
                if (e.err != 0) begin
                    chk("dut0_fail_idx", {22'd0, fidx0}, {22'd0, e.fidx});
                    chk("dut0_fail_out", {28'd0, fout0}, {28'd0, e.fout});
                    chk("dut0_fail_cout", {31'd0, fcout0}, {31'd0, e.fcout});
                end
            end
        end
        done0_q = done0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (done2 && !done2_q) begin
            if (q2.size() == 0) begin
                chk("dut2_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q2.pop_front();
                chk("dut2_done_cycle", cyc, e.cyc);
                chk("dut2_err_count", {21'd0, err2}, {21'd0, e.err});
                chk("dut2_pass", {31'd0, pass2}, {31'd0, e.pass});
                if (e.err != 0) begin
                    chk("dut2_fail_idx", {22'd0, fidx2}, {22'd0, e.fidx});
                    chk("dut2_fail_out", {28'd0, fout2}, {28'd0, e.fout});
                    chk("dut2_fail_cout", {31'd0, fcout2}, {31'd0, e.fcout});
                end
            end
        end
        done2_q = done2;
    end

    // s = edge count including the edge that sampled start.
    task automatic pulse_start0(output int unsigned s);
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        s = cyc;
        start0 = 1'b0;
    endtask

    task automatic pulse_start2(output int unsigned s);
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        s = cyc;
        start2 = 1'b0;
    endtask

    task automatic wait_done0(input string name);
        int n = 0;
        while (!done0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!done0) chk(name, 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_done2(input string name);
        int n = 0;
        while (!done2 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!done2) chk(name, 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic push0(input logic [10:0] err, input logic [9:0] fidx, input logic [3:0] fout,
                         input logic fcout, input logic p, input int unsigned c);
        exp_t e;
        e.err = err; e.fidx = fidx; e.fout = fout; e.fcout = fcout; e.pass = p; e.cyc = c;
        q0.push_back(e);
    endtask

    task automatic push2(input logic [10:0] err, input logic [9:0] fidx, input logic [3:0] fout,
                         input logic fcout, input logic p, input int unsigned c);
        exp_t e;
        e.err = err; e.fidx = fidx; e.fout = fout; e.fcout = fcout; e.pass = p; e.cyc = c;
        q2.push_back(e);
    endtask

    initial begin
        int unsigned s;
        int n;

        repeat (3) @(negedge clk);
        chk("reset_drive0", {22'd0, ctrl0, cin0, in1_0, in2_0}, 32'd0);
        chk("reset_flags0", {29'd0, busy0, done0, pass0}, 32'd0);
        chk("reset_fail0", {err0, fidx0, fout0, fcout0}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Correct DUT; spot-check the drive and ignore a mid-run start.
        fault0 = 0;
        pulse_start0(s);
        push0(11'd0, 10'd0, 4'd0, 1'b0, 1'b1, s + 1024);
        @(negedge clk);
        chk("busy_in_run", {31'd0, busy0}, 32'd1);
        while (cyc != s + 883) @(negedge clk);
        chk("spot_drive", {22'd0, ctrl0, cin0, in1_0, in2_0}, 32'h373);
        chk("spot_golden", {27'd0, dcout0, dout0}, 32'b1_0100);
        chk("spot_no_err", {21'd0, err0}, 32'd0);
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done0("dut0_good_timeout");
        repeat (4) @(negedge clk);
        chk("done_held", {31'd0, done0}, 32'd1);

        // out[0] stuck at 0, started from DONE.
        fault0 = 1;
        pulse_start0(s);
        push0(11'd512, 10'h001, 4'b0000, 1'b0, 1'b0, s + 1024);
        wait_done0("dut0_stuck_timeout");

        // Inverted carry_out.
        fault0 = 2;
        pulse_start0(s);
        push0(11'd1024, 10'h000, 4'b0000, 1'b1, 1'b0, s + 1024);
        wait_done0("dut0_invcout_timeout");

        // Restart from DONE clears the previous error count.
        fault0 = 0;
        pulse_start0(s);
        push0(11'd0, 10'd0, 4'd0, 1'b0, 1'b1, s + 1024);
        wait_done0("dut0_restart_timeout");

        // Reset mid-run at idx 300; the run is abandoned.
        pulse_start0(s);
        n = 0;
        while ({ctrl0, cin0, in1_0, in2_0} != 10'd300 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_idx300", {22'd0, ctrl0, cin0, in1_0, in2_0}, 32'd300);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_drive", {22'd0, ctrl0, cin0, in1_0, in2_0}, 32'd0);
        chk("midrst_flags", {29'd0, busy0, done0, pass0}, 32'd0);
        chk("midrst_fail", {err0, fidx0, fout0, fcout0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_after_rst", {30'd0, busy0, done0}, 32'd0);
        pulse_start0(s);
        push0(11'd0, 10'd0, 4'd0, 1'b0, 1'b1, s + 1024);
        wait_done0("dut0_after_rst_timeout");

        // LAT = 2 with inverted carry_out: first compare on the 3rd edge.
        fault2 = 2;
        pulse_start2(s);
        push2(11'd1024, 10'h000, 4'b0000, 1'b1, 1'b0, s + 1026);
        while (cyc != s + 2) @(negedge clk);
        chk("lat2_no_cmp_edge2", {21'd0, err2}, 32'd0);
        @(negedge clk);
        chk("lat2_cmp_edge3", {21'd0, err2}, 32'd1);
        wait_done2("dut2_invcout_timeout");

        // LAT = 2, correct DUT.
        fault2 = 0;
        pulse_start2(s);
        push2(11'd0, 10'd0, 4'd0, 1'b0, 1'b1, s + 1026);
        wait_done2("dut2_good_timeout");

        chk("scoreboard_drained", q0.size() + q2.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
